// File: rtl/nco_pkg.sv
// Shared widths and FSM encoding for the time-multiplexed NCO scheduler.
package nco_pkg;

   localparam int LUT_PW = 12;
   localparam int LUT_DW = 17;
   localparam int ACC_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } nco_state_e;

   // LUT phase is the accumulator MSBs plus the channel offset, wrapping mod 4096.
   function automatic logic [LUT_PW-1:0] acc2phase(input logic [ACC_W-1:0]  acc,
                                                   input logic [LUT_PW-1:0] off);
      return acc[ACC_W-1 -: LUT_PW] + off;
   endfunction

endpackage

// File: rtl/nco_tag_pipe.sv
// Delay line carrying (valid, channel tag) alongside the shared sincos pipeline.
module nco_tag_pipe #(
   parameter int DEPTH = 3,
   parameter int CHW   = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vld_i,
   input  logic [CHW-1:0] ch_i,
   output logic           vld_o,
   output logic [CHW-1:0] ch_o
);

   logic [DEPTH-1:0]          vld_q;
   logic [DEPTH-1:0][CHW-1:0] ch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         ch_q  <= '0;
      end else begin
         vld_q[0] <= vld_i;
         ch_q[0]  <= ch_i;
         for (int k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            ch_q[k]  <= ch_q[k-1];
         end
      end
   end

   assign vld_o = vld_q[DEPTH-1];
   assign ch_o  = ch_q[DEPTH-1];

endmodule

// File: rtl/nco_lut_sched.sv
// Shares one sincos LUT between NCH phase accumulators, issuing one channel per
// cycle per frame and re-tagging the returning samples with their channel index.
module nco_lut_sched
   import nco_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CHW = 2,
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [CHW-1:0]    cfg_addr,
   input  logic [31:0]       cfg_data,
   input  logic              acc_clr,
   input  logic              frame_stb,
   output logic [LUT_PW-1:0] lut_phase,
   input  logic [LUT_DW-1:0] lut_sin,
   input  logic [LUT_DW-1:0] lut_cos,
   output logic              out_valid,
   output logic [CHW-1:0]    out_ch,
   output logic [LUT_DW-1:0] out_sin,
   output logic [LUT_DW-1:0] out_cos,
   output logic              busy,
   output logic              overrun
);

   localparam int CNTW = 8;

   nco_state_e state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic [NCH-1:0][ACC_W-1:0]  ftw_sh_q, ftw_q, ftw_use;
   logic [NCH-1:0][LUT_PW-1:0] off_sh_q, off_q, off_use;
   logic [NCH-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic                       clr_pend_q;
   logic [LUT_PW-1:0]          lut_phase_q, lut_phase_d;

   logic                       accept;
   logic                       issue_vld;
   logic [CHW-1:0]             issue_ch;
   logic                       tag_vld;
   logic [CHW-1:0]             tag_ch;

   logic                       out_valid_q;
   logic [CHW-1:0]             out_ch_q;
   logic [LUT_DW-1:0]          out_sin_q, out_cos_q;

   assign accept = (state_q == ST_IDLE) && frame_stb;

   // Channel 0 issues on the accept edge, so it must see the shadow values
   // that the active copies are loading on that same edge.
   assign ftw_use = accept ? ftw_sh_q : ftw_q;
   assign off_use = accept ? off_sh_q : off_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      issue_vld = 1'b0;
      issue_ch  = '0;
      case (state_q)
         ST_IDLE: begin
            if (frame_stb) begin
               state_d   = ST_ISSUE;
               cnt_d     = '0;
               issue_vld = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == CNTW'(NCH - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               issue_vld = 1'b1;
               issue_ch  = CHW'(cnt_q + 1'b1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNTW'(LAT)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      acc_d       = acc_q;
      lut_phase_d = lut_phase_q;
      if (accept && clr_pend_q) acc_d = '0;
      if (issue_vld) begin
         lut_phase_d       = acc2phase(acc_d[issue_ch], off_use[issue_ch]);
         acc_d[issue_ch]   = acc_d[issue_ch] + ftw_use[issue_ch];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ftw_sh_q    <= '0;
         off_sh_q    <= '0;
         ftw_q       <= '0;
         off_q       <= '0;
         acc_q       <= '0;
         clr_pend_q  <= 1'b0;
         lut_phase_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         lut_phase_q <= lut_phase_d;
         if (accept) begin
            ftw_q      <= ftw_sh_q;
            off_q      <= off_sh_q;
            clr_pend_q <= acc_clr;
         end else if (acc_clr) begin
            clr_pend_q <= 1'b1;
         end
         if (cfg_we) begin
            if (cfg_sel) off_sh_q[cfg_addr] <= cfg_data[LUT_PW-1:0];
            else         ftw_sh_q[cfg_addr] <= cfg_data;
         end
      end
   end

   nco_tag_pipe #(
      .DEPTH (LAT + 1),
      .CHW   (CHW)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .vld_i (issue_vld),
      .ch_i  (issue_ch),
      .vld_o (tag_vld),
      .ch_o  (tag_ch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_sin_q   <= '0;
         out_cos_q   <= '0;
      end else begin
         out_valid_q <= tag_vld;
         if (tag_vld) begin
            out_ch_q  <= tag_ch;
            out_sin_q <= lut_sin;
            out_cos_q <= lut_cos;
         end
      end
   end

   assign lut_phase = lut_phase_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_sin   = out_sin_q;
   assign out_cos   = out_cos_q;
   assign busy      = (state_q != ST_IDLE);
   // Flagged in the same cycle as the rejected strobe.
   assign overrun   = frame_stb && (state_q != ST_IDLE);

endmodule

// File: tb/tb_nco_lut_sched.sv
// Bench for nco_lut_sched: directed scenarios plus random traffic against a
// frame-level reference model with a delayed-LUT stub.
module tb_nco_lut_sched;

   localparam int NCH  = 4;
   localparam int CHW  = 2;
   localparam int LAT  = 2;
   localparam int MAXC = 2048;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_we = 1'b0, cfg_sel = 1'b0;
   logic [CHW-1:0] cfg_addr = '0;
   logic [31:0]    cfg_data = '0;
   logic           acc_clr = 1'b0, frame_stb = 1'b0;
   logic [11:0]    lut_phase;
   logic [16:0]    lut_sin, lut_cos;
   logic           out_valid, busy, overrun;
   logic [CHW-1:0] out_ch;
   logic [16:0]    out_sin, out_cos;

   nco_lut_sched #(.NCH(NCH), .CHW(CHW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .acc_clr(acc_clr), .frame_stb(frame_stb),
      .lut_phase(lut_phase), .lut_sin(lut_sin), .lut_cos(lut_cos),
      .out_valid(out_valid), .out_ch(out_ch), .out_sin(out_sin), .out_cos(out_cos),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // LUT stub: LAT-cycle delay, sin = phase, cos = ~phase (zero-extended).
   logic [11:0] lp [LAT] = '{default: '0};
   always @(posedge clk) begin
      lp[0] <= lut_phase;
      for (int k = 1; k < LAT; k++) lp[k] <= lp[k-1];
   end
   assign lut_sin = {5'b0, lp[LAT-1]};
   assign lut_cos = {5'b0, ~lp[LAT-1]};

   int checks = 0, errors = 0, cyc = 0;

   // reference model state
   logic [31:0] m_acc [NCH], m_ftw [NCH];
   logic [11:0] m_off [NCH];
   bit          m_pend;
   int          m_bs, m_be;
   logic [11:0] exp_ph  [MAXC];
   bit          exp_phv [MAXC];
   bit          exp_ov  [MAXC];
   logic [CHW-1:0] exp_och [MAXC];
   logic [11:0] exp_oph [MAXC];
   logic [11:0] cur_ph;
   logic [16:0] cur_sin, cur_cos;

   logic [11:0]    obs_ph   [MAXC];
   bit             obs_vld  [MAXC], obs_ov [MAXC], obs_busy [MAXC];
   logic [CHW-1:0] obs_och  [MAXC];
   logic [16:0]    obs_sin  [MAXC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int k = cyc; k < MAXC; k++) begin
         exp_phv[k] = 1'b0; exp_ov[k] = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = '0; m_ftw[i] = '0; m_off[i] = '0;
      end
      m_pend = 1'b0; m_bs = 1; m_be = 0;
      cur_ph = '0; cur_sin = '0; cur_cos = '0;
   endtask

   task automatic step(input bit f, input bit clr, input bit we, input bit sel,
                       input int addr, input logic [31:0] data, input bit r);
      bit          busy_e, ov_e;
      logic [11:0] ph;
      @(negedge clk);
      cyc++;
      frame_stb = f; acc_clr = clr; cfg_we = we; cfg_sel = sel;
      cfg_addr = CHW'(addr); cfg_data = data; rst = r;
      busy_e = 1'b0; ov_e = 1'b0;
      if (r) model_reset();
      else begin
         busy_e = (cyc >= m_bs) && (cyc <= m_be);
         ov_e   = f && busy_e;
         if (f && !busy_e) begin
            if (m_pend) for (int i = 0; i < NCH; i++) m_acc[i] = '0;
            m_pend = clr;
            for (int i = 0; i < NCH; i++) begin
               ph = 12'(m_acc[i] >> 20) + m_off[i];
               m_acc[i] = m_acc[i] + m_ftw[i];
               exp_phv[cyc+1+i] = 1'b1; exp_ph[cyc+1+i] = ph;
               exp_ov[cyc+LAT+2+i] = 1'b1;
               exp_och[cyc+LAT+2+i] = CHW'(i);
               exp_oph[cyc+LAT+2+i] = ph;
            end
            m_bs = cyc + 1; m_be = cyc + NCH + LAT + 1;
         end else if (clr) m_pend = 1'b1;
         if (we) begin
            if (sel) m_off[addr] = data[11:0];
            else     m_ftw[addr] = data;
         end
      end
      if (exp_phv[cyc]) cur_ph = exp_ph[cyc];
      if (exp_ov[cyc]) begin
         cur_sin = {5'b0, exp_oph[cyc]};
         cur_cos = {5'b0, ~exp_oph[cyc]};
      end
      #1;
      chk("busy", 32'(busy), 32'(busy_e));
      chk("overrun", 32'(overrun), 32'(ov_e));
      chk("lut_phase", 32'(lut_phase), 32'(cur_ph));
      chk("out_valid", 32'(out_valid), 32'(exp_ov[cyc]));
      if (exp_ov[cyc]) chk("out_ch", 32'(out_ch), 32'(exp_och[cyc]));
      if (r) chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("out_sin", 32'(out_sin), 32'(cur_sin));
      chk("out_cos", 32'(out_cos), 32'(cur_cos));
      obs_ph[cyc] = lut_phase; obs_vld[cyc] = out_valid; obs_ov[cyc] = overrun;
      obs_busy[cyc] = busy; obs_och[cyc] = out_ch; obs_sin[cyc] = out_sin;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 32'd0, 0);
   endtask
   task automatic wr(input bit sel, input int addr, input logic [31:0] data);
      step(0, 0, 1, sel, addr, data, 0);
   endtask
   task automatic fr(output int t);
      step(1, 0, 0, 0, 0, 32'd0, 0);
      t = cyc;
   endtask

   initial begin
      int t0, t1, t2, ta, tb, tc, tfirst, nvld, bad, k;
      logic [11:0] d;
      model_reset();

      // reset state
      repeat (3) step(0, 0, 0, 0, 0, 32'd0, 1);
      idle(2);

      // reset in the middle of ISSUE aborts the frame
      wr(0, 0, 32'h0010_0000);
      fr(t0);
      idle(1);
      step(0, 0, 0, 0, 0, 32'd0, 1);
      chk("rst_mid_phase", 32'(lut_phase), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      idle(9);
      nvld = 0;
      for (int c = t0 + 2; c <= cyc; c++) nvld += int'(obs_vld[c]);
      chk("rst_mid_no_valid", 32'(nvld), 32'd0);

      // ch0 FTW steps one LUT code per frame
      wr(0, 0, 32'h0010_0000);
      fr(t0); idle(9);
      fr(t1); idle(9);
      fr(t2); idle(9);
      chk("ftw0_f1", 32'(obs_ph[t0+1]), 32'h000);
      chk("ftw0_f2", 32'(obs_ph[t1+1]), 32'h001);
      chk("ftw0_f3", 32'(obs_ph[t2+1]), 32'h002);
      chk("ftw0_sin_f3", 32'(obs_sin[t2+LAT+2]), 32'h002);
      chk("ftw0_vld_f3", 32'(obs_vld[t2+LAT+2]), 32'd1);

      // half-turn FTW, offsets and offset wrap
      wr(0, 1, 32'h8000_0000);
      wr(1, 2, 32'h0000_0400);
      wr(0, 2, 32'h0000_0000);
      wr(1, 3, 32'h0000_0FFF);
      wr(0, 3, 32'h0010_0000);
      fr(ta); idle(9);
      fr(tb); idle(9);
      chk("ph_f1_ch1", 32'(obs_ph[ta+2]), 32'h000);
      chk("ph_f1_ch2", 32'(obs_ph[ta+3]), 32'h400);
      chk("ph_f1_ch3", 32'(obs_ph[ta+4]), 32'hFFF);
      chk("ph_f2_ch1", 32'(obs_ph[tb+2]), 32'h800);
      chk("ph_f2_ch3", 32'(obs_ph[tb+4]), 32'h000);

      // strobe while busy is dropped; first idle cycle accepts
      fr(t0); idle(6);
      fr(t1);
      fr(t2);
      idle(10);
      chk("ovr_pulse", 32'(obs_ov[t1]), 32'd1);
      chk("ovr_accept_clean", 32'(obs_ov[t2]), 32'd0);
      chk("ovr_accept_busy", 32'(obs_busy[t2+1]), 32'd1);
      chk("ovr_last_busy", 32'(obs_busy[t0+NCH+LAT+1]), 32'd1);

      // FTW written with the strobe only applies from the next frame
      step(1, 0, 1, 0, 0, 32'h0030_0000, 0); ta = cyc; idle(9);
      fr(tb); idle(9);
      fr(tc); idle(9);
      d = obs_ph[tb+1] - obs_ph[ta+1];
      chk("cfg_same_cyc_old", 32'(d), 32'd1);
      d = obs_ph[tc+1] - obs_ph[tb+1];
      chk("cfg_same_cyc_new", 32'(d), 32'd3);

      // pending acc_clr zeroes accumulators, so only offsets remain
      step(0, 1, 0, 0, 0, 32'd0, 0);
      idle(1);
      fr(tc); idle(9);
      chk("clr_ch0", 32'(obs_ph[tc+1]), 32'h000);
      chk("clr_ch1", 32'(obs_ph[tc+2]), 32'h000);
      chk("clr_ch2", 32'(obs_ph[tc+3]), 32'h400);
      chk("clr_ch3", 32'(obs_ph[tc+4]), 32'hFFF);

      // back-to-back frames with random config traffic
      tfirst = cyc + 1;
      for (int n = 0; n < 20; n++) begin
         fr(t0);
         for (int j = 0; j < NCH + LAT + 1; j++)
            step(0, 0, ($urandom_range(0, 1) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, NCH - 1)), $urandom, 0);
      end
      idle(LAT + 3);
      nvld = 0; bad = 0; k = 0;
      for (int c = tfirst; c <= cyc; c++) begin
         if (obs_vld[c]) begin
            nvld++;
            if (int'(obs_och[c]) != (k % NCH)) bad++;
            k++;
         end
      end
      chk("b2b_vld_count", 32'(nvld), 32'(20 * NCH));
      chk("b2b_ch_seq", 32'(bad), 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bit f, c2;
         f  = ($urandom_range(0, 3) == 0);
         c2 = !f && ($urandom_range(0, 39) == 0);
         step(f, c2, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, NCH - 1)), $urandom, 0);
      end
      idle(NCH + LAT + 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nco_lut_sched.md
Name: nco_lut_sched

Overview:
- Time-multiplexed NCO scheduler that shares one sincos LUT (12-bit phase in, 17-bit sin/cos out, fixed pipeline latency) between NCH channels.
- Holds per-channel 32-bit phase accumulators, frequency tuning words and phase offsets.
- On each frame strobe, issues one LUT phase per channel per cycle and re-tags the returning samples with their channel index.
- Sits between the config bus and the sincos instance; feeds the per-channel mixers of the SDR datapath.

Parameters:
- NCH, 4, number of NCO channels sharing the LUT (power of 2, 2..16).
- CHW, 2, channel index width = log2(NCH).
- LAT, 2, clocks from lut_phase to valid lut_sin/lut_cos (sincos pipeline depth).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  shadow register write strobe.
- cfg_sel  in  1  0 = write FTW, 1 = write phase offset.
- cfg_addr  in  CHW  channel index of the write.
- cfg_data  in  32  FTW (all 32 bits) or phase offset (bits [11:0]).
- acc_clr  in  1  request: zero all accumulators at next accepted frame start.
- frame_stb  in  1  one-cycle frame start request.
- lut_phase  out  12  registered phase to sincos.
- lut_sin  in  17  sincos sin result.
- lut_cos  in  17  sincos cos result.
- out_valid  out  1  out_* carry a sample this cycle.
- out_ch  out  CHW  channel tag of the sample.
- out_sin  out  17  registered copy of lut_sin.
- out_cos  out  17  registered copy of lut_cos.
- busy  out  1  frame in progress.
- overrun  out  1  one-cycle pulse: frame_stb dropped.

Behaviour:
- Reset (async, active-high): accumulators, shadow/active FTW and offset = 0; acc_clr pending flag = 0; state IDLE; all outputs 0.
- Config:
  - cfg_we writes the shadow register selected by cfg_sel/cfg_addr on the next edge.
  - Active copies load from shadow only when a frame is accepted, so parameters never change mid-frame.
  - A write in the same cycle as an accepted frame_stb is not used by that frame; it takes effect at the following frame.
- acc_clr sets a sticky pending flag. At the next accepted frame the accumulators are zeroed before issue and the flag clears.
- FSM states IDLE, ISSUE, DRAIN:
  - IDLE: frame_stb = 1 → frame accepted; load active regs; issue counter = 0; go to ISSUE.
  - ISSUE: each cycle output lut_phase = acc[i][31:20] + off[i] (mod 4096), then acc[i] <= acc[i] + ftw[i] (mod 2^32). After i = NCH-1, go to DRAIN.
  - DRAIN: LAT+1 cycles, then IDLE.
- Timing (frame_stb high in cycle t):
  - lut_phase for channel i is valid in cycle t+1+i.
  - out_valid and out_ch = i in cycle t+LAT+2+i; out_valid is high for exactly NCH consecutive cycles.
  - busy is high over cycles t+1 .. t+NCH+LAT+1.
- Tag alignment: a (valid, ch) shift pipe of LAT+1 stages. out_sin/out_cos hold their last value when out_valid = 0.
- frame_stb sampled while busy = 1: ignored, overrun = 1 for one cycle. Accumulators and shadows are untouched.
- First cycle busy = 0 accepts frame_stb.
- lut_phase holds its last value outside ISSUE.
- Async reset mid-frame: aborts immediately to the reset state; no out_valid afterwards until a new frame.

Decomposition:
- Shared package nco_pkg: LUT_PW = 12, LUT_DW = 17, ACC_W = 32, state encoding constants.
- One natural sub-module: nco_tag_pipe (parameterised LAT+1 delay line carrying valid + channel tag).

Test Plan:
- Reset mid-ISSUE (NCH=4, LAT=2, frame at t=10, rst at t=12) → outputs 0 immediately; no out_valid in t=12..20.
- ftw[0] = 0x00100000, 3 frames spaced 10 cycles → ch0 lut_phase 0x000, 0x001, 0x002. With a LUT model returning {5'b0, phase}, out_sin = phase with out_ch = 0 at t+4.
- ftw[1] = 0x80000000, off[2] = 0x400 with ftw[2] = 0, off[3] = 0xFFF with ftw[3] = 0x00100000 → frame 1: ch1 0x000, ch2 0x400, ch3 0xFFF; frame 2: ch1 0x800, ch3 0x000 (wrap).
- frame_stb at t and again at t+7 → second is dropped, overrun pulses at t+7; frame_stb at t+8 is accepted with no overrun.
- cfg write of ftw[0] in the same cycle as frame_stb → that frame uses the old FTW; the next frame reflects the new one. acc_clr before frame → all channels issue off[i] only.
- Back-to-back frames → out_valid high 4 cycles per frame; out_ch sequence 0, 1, 2, 3; no gaps or duplicates across 20 frames vs. reference model.
